btn_conditioner: RTL



---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_channel.sv | 132 +++++++++++++
 rtl/btn_conditioner.sv | 46 ++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button conditioning stage.
package btn_pkg;

  localparam int unsigned BTN_JUMP   = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_ENABLE = 2;
  localparam int unsigned BTN_RST    = 3;

  localparam int unsigned DEF_NUM_BTN         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms at 50 MHz
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz
  localparam logic [3:0]  DEF_REPEAT_EN       = 4'b0011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debouncer, press/release pulses and auto-repeat FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [1:0]        r_sync;
  logic              r_level;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_press;
  logic              r_release;
  logic              r_repeat;
  rpt_state_t        r_state;
  logic [RCNT_W-1:0] r_rcnt;

  logic              w_diff;
  logic              w_flip;
  logic              w_rise;
  logic              w_fall;
  rpt_state_t        w_state_nxt;
  logic [RCNT_W-1:0] w_rcnt_nxt;
  logic              w_repeat_nxt;

  assign w_diff = r_sync[1] ^ r_level;
  assign w_flip = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_rise = w_flip & ~r_level;
  assign w_fall = w_flip & r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

  // Any cycle where the synchronised input agrees with the level restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rcnt   <= w_rcnt_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rcnt_nxt   = r_rcnt;
    w_repeat_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && i_repeat_en) begin
          w_state_nxt = WAIT;
          w_rcnt_nxt  = '0;
        end
      end
      WAIT: begin
        if (r_rcnt == RCNT_W'(REPEAT_DELAY - 1)) begin
          w_repeat_nxt = 1'b1;
          w_rcnt_nxt   = '0;
          w_state_nxt  = REPEAT;
        end else begin
          w_rcnt_nxt = r_rcnt + RCNT_W'(1);
        end
      end
      REPEAT: begin
        if (r_rcnt == RCNT_W'(REPEAT_PERIOD - 1)) begin
          w_repeat_nxt = 1'b1;
          w_rcnt_nxt   = '0;
        end else begin
          w_rcnt_nxt = r_rcnt + RCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rcnt_nxt  = '0;
      end
    endcase
    // Release wins over a coincident repeat.
    if (w_fall) begin
      w_state_nxt  = IDLE;
      w_rcnt_nxt   = '0;
      w_repeat_nxt = 1'b0;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw asynchronous button pins into clean levels and pulses for the game core.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned         NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [NUM_BTN-1:0]  REPEAT_EN       = NUM_BTN'(DEF_REPEAT_EN),
  parameter int unsigned         REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned         REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  logic [NUM_BTN-1:0] w_repeat;

  for (genvar gi = 0; gi < int'(NUM_BTN); gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .i_clk       (clk),
      .i_rst       (clr),
      .i_raw       (btn_raw[gi]),
      .i_repeat_en (REPEAT_EN[gi]),
      .o_level     (btn_level[gi]),
      .o_press     (btn_press[gi]),
      .o_release   (btn_release[gi]),
      .o_repeat    (w_repeat[gi])
    );

    // Masked channels are hard-tied low so downstream sees a constant.
    if (REPEAT_EN[gi]) begin : g_rep
      assign btn_repeat[gi] = w_repeat[gi];
    end else begin : g_norep
      assign btn_repeat[gi] = 1'b0;
    end
  end

endmodule
